// File: rtl/dmem_hs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_hs : single-port data memory with req/ready handshake,        |
// |           wait states, byte lanes and out-of-range error.          |
// |           Optional macro DMEM_CLEAR_EN zero-fills RAM after reset.  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module dmem_hs #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  output logic                    ready,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    ack,
  output logic                    err,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
`ifdef DMEM_CLEAR_EN
    , S_INIT = 2'd3
`endif
  } state_t;

`ifdef DMEM_CLEAR_EN
  localparam state_t RST_STATE = S_INIT;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LANES-1:0]      r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
`ifdef DMEM_CLEAR_EN
  logic [IDX_W-1:0]      r_init_addr;
  logic                  w_clear;
`endif

  logic                  w_idle;
  logic                  w_fire;
  logic                  w_acc_we;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [LANES-1:0]      w_acc_be;
  logic [DATA_WIDTH-1:0] w_acc_wdata;
  logic                  w_in_range;
  logic                  w_wr;
  logic [IDX_W-1:0]      w_idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign w_idle = (r_state == S_IDLE);
  assign ready  = w_idle;

  // With zero wait states the access happens on the accept edge itself,
  // so the port values are used before they reach the request registers.
  assign w_fire      = rst_n && ((w_idle && req && (WAIT_CYCLES == 0)) ||
                                 ((r_state == S_WAIT) && (r_cnt == CNT_W'(1))));
  assign w_acc_we    = w_idle ? we    : r_we;
  assign w_acc_addr  = w_idle ? addr  : r_addr;
  assign w_acc_be    = w_idle ? be    : r_be;
  assign w_acc_wdata = w_idle ? wdata : r_wdata;
  assign w_in_range  = ({1'b0, w_acc_addr} < DEPTH_L);
  assign w_idx       = w_acc_addr[IDX_W-1:0];
  assign w_wr        = w_fire && w_acc_we && w_in_range;

`ifdef DMEM_CLEAR_EN
  assign w_clear = rst_n && (r_state == S_INIT);
`endif

  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
    if (w_clear) begin
      mem[r_init_addr] <= '0;
    end else
`endif
    if (w_wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_acc_be[i]) begin
          mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_STATE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      ack         <= 1'b0;
      err         <= 1'b0;
      rdata       <= '0;
`ifdef DMEM_CLEAR_EN
      r_init_addr <= '0;
`endif
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      if (w_fire) begin
        ack <= 1'b1;
        err <= !w_in_range;
        if (!w_acc_we) begin
          rdata <= w_in_range ? mem[w_idx] : '0;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_be    <= be;
            r_wdata <= wdata;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
`ifdef DMEM_CLEAR_EN
        S_INIT: begin
          if (r_init_addr == IDX_W'(DEPTH - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_init_addr <= r_init_addr + IDX_W'(1);
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_hs.sv
`default_nettype none
// Bench for dmem_hs: three instances (1, 0 and 3 wait states) checked
// against a word/lane reference model with randomized traffic.
module tb_dmem_hs;

  localparam int W_A = 1, D_A = 20, AW_A = 5;
  localparam int W_B = 0, D_B = 32, AW_B = 6;
  localparam int W_C = 3, D_C = 32, AW_C = 5;
`ifdef DMEM_CLEAR_EN
  localparam logic RDY_RST = 1'b0;
  localparam int   CLR_CYC = D_C;
`else
  localparam logic RDY_RST = 1'b1;
  localparam int   CLR_CYC = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_c;

  logic            req_a, ready_a, we_a, ack_a, err_a;
  logic [AW_A-1:0] addr_a;
  logic [1:0]      be_a;
  logic [15:0]     wdata_a, rdata_a;

  logic            req_b, ready_b, we_b, ack_b, err_b;
  logic [AW_B-1:0] addr_b;
  logic [1:0]      be_b;
  logic [15:0]     wdata_b, rdata_b;

  logic            req_c, ready_c, we_c, ack_c, err_c;
  logic [AW_C-1:0] addr_c;
  logic [1:0]      be_c;
  logic [15:0]     wdata_c, rdata_c;

  dmem_hs #(.ADDR_WIDTH(AW_A), .DATA_WIDTH(16), .DEPTH(D_A), .WAIT_CYCLES(W_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .ready(ready_a), .we(we_a), .addr(addr_a),
    .be(be_a), .wdata(wdata_a), .ack(ack_a), .err(err_a), .rdata(rdata_a));

  dmem_hs #(.ADDR_WIDTH(AW_B), .DATA_WIDTH(16), .DEPTH(D_B), .WAIT_CYCLES(W_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .ready(ready_b), .we(we_b), .addr(addr_b),
    .be(be_b), .wdata(wdata_b), .ack(ack_b), .err(err_b), .rdata(rdata_b));

  dmem_hs #(.ADDR_WIDTH(AW_C), .DATA_WIDTH(16), .DEPTH(D_C), .WAIT_CYCLES(W_C)) dut_c (
    .clk(clk), .rst_n(rst_c), .req(req_c), .ready(ready_c), .we(we_c), .addr(addr_c),
    .be(be_c), .wdata(wdata_c), .ack(ack_c), .err(err_c), .rdata(rdata_c));

  int total = 0;
  int bad   = 0;

  // Reference model: word storage plus the value rdata should be holding.
  logic [15:0] mem_a [32];
  logic [15:0] mem_b [64];
  bit          vld_b [64];
  logic [15:0] last_rd_a, last_rd_b;

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] b);
    merge = o;
    if (b[0]) merge[7:0]  = n[7:0];
    if (b[1]) merge[15:8] = n[15:8];
  endfunction

  // Drivers only: issue one request and report what was observed.
  task automatic xact_a(input logic w, input int a, input logic [1:0] b, input logic [15:0] d,
                        output int lat, output logic e, output logic [15:0] rd,
                        output logic extra, output logic rdy_seen);
    int n = 0;
    @(negedge clk);
    while (!ready_a && n < 60) begin @(negedge clk); n++; end
    req_a = 1'b1; we_a = w; addr_a = AW_A'(a); be_a = b; wdata_a = d;
    @(posedge clk); #1;
    req_a = 1'b0; we_a = 1'($urandom); addr_a = AW_A'($urandom);
    be_a = 2'($urandom); wdata_a = 16'($urandom);
    lat = 0; rdy_seen = ready_a;
    while (!ack_a && lat < 20) begin @(posedge clk); #1; lat++; rdy_seen |= ready_a; end
    if (!ack_a) lat = -1;
    e = err_a; rd = rdata_a;
    @(posedge clk); #1;
    extra = ack_a;
  endtask

  task automatic xact_c(input logic w, input int a, input logic [1:0] b, input logic [15:0] d,
                        output int lat, output logic e, output logic [15:0] rd);
    int n = 0;
    @(negedge clk);
    while (!ready_c && n < 60) begin @(negedge clk); n++; end
    req_c = 1'b1; we_c = w; addr_c = AW_C'(a); be_c = b; wdata_c = d;
    @(posedge clk); #1;
    req_c = 1'b0;
    lat = 0;
    while (!ack_c && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!ack_c) lat = -1;
    e = err_c; rd = rdata_c;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2;
    rst_n = 1'b0; rst_c = 1'b0;
    #1;
    total++;
    if (ack_a !== 1'b0 || err_a !== 1'b0 || rdata_a !== 16'h0) begin
      bad++; $display("FAIL reset_async ack=%b err=%b rdata=%h want 0/0/0000", ack_a, err_a, rdata_a);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (ready_a !== RDY_RST || ready_b !== RDY_RST || ready_c !== RDY_RST) begin
      bad++; $display("FAIL reset_ready a=%b b=%b c=%b want %b", ready_a, ready_b, ready_c, RDY_RST);
    end
    total++;
    if (ack_b !== 1'b0 || err_b !== 1'b0 || rdata_b !== 16'h0 || ack_c !== 1'b0 || rdata_c !== 16'h0) begin
      bad++; $display("FAIL reset_outputs ack_b=%b err_b=%b rdata_b=%h ack_c=%b rdata_c=%h want zeros",
                      ack_b, err_b, rdata_b, ack_c, rdata_c);
    end
    rst_n = 1'b1; rst_c = 1'b1;
    last_rd_a = 16'h0; last_rd_b = 16'h0;
  endtask

  task automatic test_basic;
    int lat; logic e, x, rs; logic [15:0] rd;
    xact_a(1'b1, 3, 2'b11, 16'hA5C3, lat, e, rd, x, rs);
    mem_a[3] = 16'hA5C3;
    total++;
    if (lat !== W_A || x !== 1'b0 || rs !== 1'b0 || e !== 1'b0) begin
      bad++; $display("FAIL basic_write lat=%0d extra_ack=%b ready=%b err=%b want lat=%0d 0 0 0", lat, x, rs, e, W_A);
    end
    xact_a(1'b0, 3, 2'b00, 16'h0, lat, e, rd, x, rs);
    last_rd_a = mem_a[3];
    total++;
    if (lat !== W_A || x !== 1'b0 || rs !== 1'b0 || e !== 1'b0) begin
      bad++; $display("FAIL basic_read_timing lat=%0d extra_ack=%b ready=%b err=%b want lat=%0d 0 0 0", lat, x, rs, e, W_A);
    end
    total++;
    if (rd !== 16'hA5C3) begin bad++; $display("FAIL basic_read_data got=%h want=a5c3", rd); end
  endtask

  task automatic test_byte_lanes;
    int lat; logic e, x, rs; logic [15:0] rd;
    xact_a(1'b1, 7, 2'b11, 16'hFFFF, lat, e, rd, x, rs);
    xact_a(1'b1, 7, 2'b01, 16'h1234, lat, e, rd, x, rs);
    total++;
    if (rd !== last_rd_a) begin bad++; $display("FAIL lanes_write_keeps_rdata got=%h want=%h", rd, last_rd_a); end
    xact_a(1'b0, 7, 2'b00, 16'h0, lat, e, rd, x, rs);
    total++;
    if (rd !== 16'hFF34) begin bad++; $display("FAIL lanes_low got=%h want=ff34", rd); end
    xact_a(1'b1, 7, 2'b10, 16'hABCD, lat, e, rd, x, rs);
    xact_a(1'b1, 7, 2'b00, 16'h5555, lat, e, rd, x, rs);
    total++;
    if (lat !== W_A || e !== 1'b0) begin bad++; $display("FAIL lanes_be0_ack lat=%0d err=%b want %0d 0", lat, e, W_A); end
    xact_a(1'b0, 7, 2'b00, 16'h0, lat, e, rd, x, rs);
    total++;
    if (rd !== 16'hAB34) begin bad++; $display("FAIL lanes_high_be0 got=%h want=ab34", rd); end
    mem_a[7] = 16'hAB34; last_rd_a = 16'hAB34;
  endtask

  task automatic test_error;
    int lat; logic e, x, rs; logic [15:0] rd;
    xact_a(1'b0, 25, 2'b00, 16'h0, lat, e, rd, x, rs);
    total++;
    if (lat !== W_A || e !== 1'b1 || rd !== 16'h0 || x !== 1'b0) begin
      bad++; $display("FAIL err_read lat=%0d err=%b rdata=%h extra=%b want %0d 1 0000 0", lat, e, rd, x, W_A);
    end
    xact_a(1'b0, 3, 2'b00, 16'h0, lat, e, rd, x, rs);
    total++;
    if (e !== 1'b0 || rd !== 16'hA5C3) begin
      bad++; $display("FAIL err_recover err=%b rdata=%h want 0 a5c3", e, rd);
    end
    xact_a(1'b1, D_A, 2'b11, 16'h7777, lat, e, rd, x, rs);
    total++;
    if (e !== 1'b1 || rd !== 16'hA5C3) begin
      bad++; $display("FAIL err_write err=%b rdata=%h want 1 a5c3", e, rd);
    end
    last_rd_a = 16'hA5C3;
  endtask

  task automatic test_random;
    int lat, a; logic e, x, rs, w; logic [1:0] b; logic [15:0] d, rd, exp_rd; logic exp_err;
    for (int i = 0; i < D_A; i++) begin
      if (i != 3 && i != 7) begin
        d = 16'($urandom);
        xact_a(1'b1, i, 2'b11, d, lat, e, rd, x, rs);
        mem_a[i] = d;
      end
    end
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom); a = int'($urandom_range(0, 31)); b = 2'($urandom); d = 16'($urandom);
      xact_a(w, a, b, d, lat, e, rd, x, rs);
      exp_err = (a >= D_A);
      if (w && !exp_err) mem_a[a] = merge(mem_a[a], d, b);
      if (!w) last_rd_a = exp_err ? 16'h0 : mem_a[a];
      exp_rd = last_rd_a;
      total++;
      if (lat !== W_A || x !== 1'b0 || rs !== 1'b0) begin
        bad++; $display("FAIL rand_timing op=%0d lat=%0d extra=%b ready=%b want %0d 0 0", i, lat, x, rs, W_A);
      end
      total++;
      if (e !== exp_err) begin bad++; $display("FAIL rand_err op=%0d addr=%0d got=%b want=%b", i, a, e, exp_err); end
      total++;
      if (rd !== exp_rd) begin
        bad++; $display("FAIL rand_rdata op=%0d we=%b addr=%0d got=%h want=%h", i, w, a, rd, exp_rd);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n = 0, acc = 0, a; logic w, rdy, exp_err; logic [1:0] b; logic [15:0] d;
    while (!ready_b && n < 60) begin @(negedge clk); n++; end
    exp_err = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      w = 1'($urandom); a = int'($urandom_range(0, 47)); b = 2'($urandom); d = 16'($urandom);
      if (a < D_B && !vld_b[a]) begin w = 1'b1; b = 2'b11; end
      req_b = 1'b1; we_b = w; addr_b = AW_B'(a); be_b = b; wdata_b = d;
      rdy = ready_b;
      @(posedge clk); #1;
      if (rdy) begin
        acc++;
        exp_err = (a >= D_B);
        if (w && !exp_err) begin mem_b[a] = merge(mem_b[a], d, b); vld_b[a] = 1'b1; end
        if (!w) last_rd_b = exp_err ? 16'h0 : mem_b[a];
      end
      total++;
      if (ack_b !== rdy || ready_b !== !rdy) begin
        bad++; $display("FAIL b2b_handshake cyc=%0d ack=%b ready=%b want ack=%b ready=%b", i, ack_b, ready_b, rdy, !rdy);
      end
      if (rdy) begin
        total++;
        if (err_b !== exp_err || rdata_b !== last_rd_b) begin
          bad++; $display("FAIL b2b_data cyc=%0d addr=%0d err=%b rdata=%h want %b %h", i, a, err_b, rdata_b, exp_err, last_rd_b);
        end
      end
    end
    req_b = 1'b0;
    total++;
    if (acc !== 40) begin bad++; $display("FAIL b2b_accepts got=%0d want=40", acc); end
  endtask

  task automatic test_reset_mid_op;
    int lat, n = 0, acks = 0; logic e; logic [15:0] rd;
    xact_c(1'b1, 5, 2'b11, 16'h1111, lat, e, rd);
    total++;
    if (lat !== W_C || e !== 1'b0) begin bad++; $display("FAIL midrst_prewrite lat=%0d err=%b want %0d 0", lat, e, W_C); end
    @(negedge clk);
    req_c = 1'b1; we_c = 1'b1; addr_c = AW_C'(5); be_c = 2'b11; wdata_c = 16'hBEEF;
    @(posedge clk); #1;
    req_c = 1'b0;
    @(negedge clk);
    rst_c = 1'b0;
    #1;
    total++;
    if (ack_c !== 1'b0 || err_c !== 1'b0) begin bad++; $display("FAIL midrst_async ack=%b err=%b want 0 0", ack_c, err_c); end
    repeat (5) begin @(posedge clk); #1; if (ack_c) acks++; end
    @(negedge clk);
    rst_c = 1'b1;
    while (!ready_c && n < 60) begin @(posedge clk); #1; n++; if (ack_c) acks++; end
    total++;
    if (n !== CLR_CYC) begin bad++; $display("FAIL midrst_ready_delay got=%0d want=%0d", n, CLR_CYC); end
    total++;
    if (acks !== 0) begin bad++; $display("FAIL midrst_no_ack got=%0d want=0", acks); end
    xact_c(1'b0, 5, 2'b00, 16'h0, lat, e, rd);
    total++;
`ifdef DMEM_CLEAR_EN
    if (rd !== 16'h0) begin bad++; $display("FAIL midrst_addr5 got=%h want=0000", rd); end
    xact_c(1'b0, 0, 2'b00, 16'h0, lat, e, rd);
    total++;
    if (rd !== 16'h0) begin bad++; $display("FAIL clear_addr0 got=%h want=0000", rd); end
    xact_c(1'b0, 31, 2'b00, 16'h0, lat, e, rd);
    total++;
    if (rd !== 16'h0 || e !== 1'b0) begin bad++; $display("FAIL clear_addr31 got=%h err=%b want=0000 0", rd, e); end
`else
    if (rd !== 16'h1111) begin bad++; $display("FAIL midrst_addr5 got=%h want=1111", rd); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; rst_c = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; be_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; be_b = '0; wdata_b = '0;
    req_c = 1'b0; we_c = 1'b0; addr_c = '0; be_c = '0; wdata_c = '0;
    for (int i = 0; i < 64; i++) vld_b[i] = 1'b0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_error();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
